// File: rtl/cordic_seq_ctrl.sv
// Control sequencer for the CORDIC datapath core: accepts one packed {x, y, angle}
// request, steps the core through load, N-1 micro-rotations and two result captures.
module cordic_seq_ctrl #(
   parameter int B = 14,
   parameter int N = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*B-1:0]         in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*B-1:0]         out_data,
   output logic                   busy,
   output logic [2*B-1:0]         core_data_w,
   output logic [8:1]             core_c,
   output logic [$clog2(N)-1:0]   core_cnt,
   input  logic [2*B-1:0]         core_data_r
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_ITER = CW'(N - 2);
   localparam logic [CW-1:0] CAP_CNT   = CW'(N - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ITER  = 3'd2,
      CAP_X = 3'd3,
      CAP_Y = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     count_reg, count_next;
   logic [2*B-1:0]    data_w_reg;
   logic              load_en;

   assign core_data_w = data_w_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         data_w_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         if (load_en) begin
            data_w_reg <= in_data;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      load_en    = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      busy       = 1'b1;
      core_c     = '0;
      core_cnt   = '0;
      case (state_reg)
         IDLE: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            if (in_valid) begin
               load_en    = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            core_c[1]  = 1'b1;
            core_c[2]  = 1'b1;
            core_c[8]  = 1'b1;
            count_next = '0;
            state_next = ITER;
         end
         ITER: begin
            core_c[2]  = 1'b1;
            core_cnt   = count_reg;
            count_next = count_reg + 1'b1;
            if (count_reg == LAST_ITER) begin
               state_next = CAP_X;
            end
         end
         CAP_X: begin
            core_c[6]  = 1'b1;
            core_cnt   = CAP_CNT;
            state_next = CAP_Y;
         end
         CAP_Y: begin
            core_c[5]  = 1'b1;
            core_c[7]  = 1'b1;
            core_cnt   = CAP_CNT;
            state_next = DONE;
         end
         DONE: begin
            // Capture enables are low here, so the core result is stable to pass through.
            out_valid = 1'b1;
            out_data  = core_data_r;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  load_en    = 1'b1;
                  state_next = LOAD;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
